// File: rtl/electronica_uabc_mexicali_2023.sv
// Seven-segment digit counter: prescaled tick advances a digit shown on uo_out and in binary on uio_out.
// Optional macro HEX_DISPLAY_EN widens the count to 0..F with hex glyphs; default counts 0..9.
module electronica_uabc_mexicali_2023 #(
  parameter int unsigned CLK_DIV = 10_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [23:0] DEFAULT_PERIOD = 24'(CLK_DIV);
`ifdef HEX_DISPLAY_EN
  localparam logic [3:0] DIGIT_LAST = 4'd15;
`else
  localparam logic [3:0] DIGIT_LAST = 4'd9;
`endif

  logic [23:0] period_reg;
  logic [23:0] period_next;
  logic [23:0] cnt_reg;
  logic [3:0]  digit_reg;
  logic        dp_reg;
  logic        tick;
  logic [6:0]  seg;
  logic        unused_inputs;

  assign unused_inputs = ^uio_in;

  // Nonzero select gives a period of ui_in * 1024 clocks.
  assign period_next = (ui_in == 8'd0) ? DEFAULT_PERIOD : {6'd0, ui_in, 10'd0};
  assign tick        = ena && (cnt_reg == period_reg - 24'd1);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      period_reg <= period_next;
      cnt_reg    <= 24'd0;
      digit_reg  <= 4'd0;
      dp_reg     <= 1'b0;
    end else if (ena) begin
      if (tick) begin
        cnt_reg   <= 24'd0;
        digit_reg <= (digit_reg == DIGIT_LAST) ? 4'd0 : digit_reg + 4'd1;
        dp_reg    <= ~dp_reg;
      end else begin
        cnt_reg <= cnt_reg + 24'd1;
      end
    end
  end

  always_comb begin
    seg = 7'h00;
    case (digit_reg)
      4'd0:  seg = 7'h3F;
      4'd1:  seg = 7'h06;
      4'd2:  seg = 7'h5B;
      4'd3:  seg = 7'h4F;
      4'd4:  seg = 7'h66;
      4'd5:  seg = 7'h6D;
      4'd6:  seg = 7'h7D;
      4'd7:  seg = 7'h07;
      4'd8:  seg = 7'h7F;
      4'd9:  seg = 7'h6F;
`ifdef HEX_DISPLAY_EN
      4'd10: seg = 7'h77;
      4'd11: seg = 7'h7C;
      4'd12: seg = 7'h39;
      4'd13: seg = 7'h5E;
      4'd14: seg = 7'h79;
      4'd15: seg = 7'h71;
`endif
      default: seg = 7'h00;
    endcase
  end

  assign uo_out = {dp_reg, seg};

  // Low nibble mirrors the digit and is driven; high nibble is input-only.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_uio
      assign uio_out[gi]     = digit_reg[gi];
      assign uio_out[gi + 4] = 1'b0;
      assign uio_oe[gi]      = 1'b1;
      assign uio_oe[gi + 4]  = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_electronica_uabc_mexicali_2023.sv
// Scoreboard bench: expected display transitions are queued per phase and popped as the DUT outputs change.
module tb_electronica_uabc_mexicali_2023;

  localparam int DIV = 37;
`ifdef HEX_DISPLAY_EN
  localparam int MODULUS = 16;
`else
  localparam int MODULUS = 10;
`endif

  typedef struct {
    int         cyc;
    logic [7:0] uo;
    logic [7:0] uio;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'd0;
  logic [7:0] uio_in = 8'hA5;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   base = 0;
  bit   mon_en = 1'b0;
  exp_t sb_q[$];

  electronica_uabc_mexicali_2023 #(.CLK_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end else begin
      $display("ok   %s: %0h (cycle %0d)", tag, got, cyc);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;  10: return 7'h77; 11: return 7'h7C;
      12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; 15: return 7'h71;
      default: return 7'h00;
    endcase
  endfunction

  // Tick number t (counted from release) lands at base + t*p + offset.
  task automatic push_ticks(input int first_t, input int last_t, input int p, input int offset);
    exp_t e;
    for (int t = first_t; t <= last_t; t++) begin
      e.cyc = base + t * p + offset;
      e.uo  = {1'(t % 2), seg_of(t % MODULUS)};
      e.uio = 8'(t % MODULUS);
      sb_q.push_back(e);
    end
  endtask

  // Monitor: every change of the display must match the head of the scoreboard.
  initial begin
    logic [15:0] prev;
    exp_t e;
    prev = 16'h0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev = {uo_out, uio_out};
      end else if ({uo_out, uio_out} != prev) begin
        prev = {uo_out, uio_out};
        if (sb_q.size() == 0) begin
          chk("unexpected_change", {16'h0, uo_out, uio_out}, 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          chk("tick_uo", 32'(uo_out), 32'(e.uo));
          chk("tick_uio", 32'(uio_out), 32'(e.uio));
          chk("tick_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [7:0] sel, input int n);
    mon_en = 1'b0;
    ui_in  = sel;
    rst_n  = 1'b1;
    run(n);
    chk("rst_uo", 32'(uo_out), 32'h3F);
    chk("rst_uio", 32'(uio_out), 32'h00);
    chk("rst_oe", 32'(uio_oe), 32'h0F);
    rst_n  = 1'b0;
    base   = cyc;
    mon_en = 1'b1;
  endtask

  initial begin
    @(negedge clk);

    // Default period from CLK_DIV when ui_in is zero.
    ena = 1'b1;
    do_reset(8'd0, 2);
    push_ticks(1, 3, DIV, 0);
    run(DIV - 1);
    chk("div_before_tick", 32'(uo_out), 32'h3F);
    run(2 * DIV + 5);
    chk("div_queue_empty", 32'(sb_q.size()), 32'd0);

    // P = 1024, full decimal (or hex) cycle plus one; ui_in changes after reset are ignored.
    do_reset(8'd1, 2);
    ui_in = 8'd7;
    push_ticks(1, MODULUS + 1, 1024, 0);
    run(1023);
    chk("p1024_edge1023", 32'(uo_out), 32'h3F);
    run(1);
    chk("p1024_edge1024", 32'(uo_out), 32'h86);
    run((MODULUS + 1) * 1024 - 1024 + 10);
    chk("p1024_queue_empty", 32'(sb_q.size()), 32'd0);

    // P = 2048 with a 500-cycle enable gap mid-period.
    do_reset(8'd2, 1);
    ui_in = 8'd200;
    push_ticks(1, 2, 2048, 500);
    run(1000);
    ena = 1'b0;
    run(500);
    ena = 1'b1;
    run(1047);
    chk("gap_edge2547", 32'(uo_out), 32'h3F);
    run(1);
    chk("gap_edge2548", 32'(uo_out), 32'h86);
    run(2048 + 10);
    chk("gap_queue_empty", 32'(sb_q.size()), 32'd0);

    // Reset mid-count at digit 5, cnt 700.
    do_reset(8'd1, 1);
    push_ticks(1, 5, 1024, 0);
    run(5 * 1024 + 700);
    chk("mid_digit5_uio", 32'(uio_out), 32'h05);
    chk("mid_queue_empty", 32'(sb_q.size()), 32'd0);
    do_reset(8'd1, 1);
    push_ticks(1, 1, 1024, 0);
    run(1023);
    chk("mid_restart_edge1023", 32'(uo_out), 32'h3F);
    run(11);
    chk("mid_restart_queue", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/electronica_uabc_mexicali_2023.md
# electronica_uabc_mexicali_2023

Free-running seven-segment digit counter for the UABC Mexicali Tiny Tapeout tile. A prescaler divides `clk` down to a tick period chosen at reset from `ui_in`. Each tick advances a one-digit counter, which is decoded onto the segment outputs and mirrored in binary on the bidirectional pins. It is the top-level user module and sits directly under the Tiny Tapeout harness.

## Interface
- `CLK_DIV`, default 10_000_000: tick period in clock cycles when `ui_in` is 0 at reset (1 Hz at 10 MHz). Must fit in 24 bits.
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-high (the name is kept from the harness; the polarity is fixed as active-high).
- `ena`  in  1  count enable; when low, all state holds.
- `ui_in`  in  8  period select, sampled only while reset is asserted.
- `uo_out`  out  8  [6:0] segments a..g (bit0=a … bit6=g), active-high, common cathode; [7] decimal point.
- `uio_in`  in  8  unused, ignored.
- `uio_out`  out  8  {4'b0000, digit[3:0]}.
- `uio_oe`  out  8  constant 8'h0F.

## Operation
- Period register P (24 bit):
  - Loaded on every clock edge where reset is high.
  - P = CLK_DIV if `ui_in` == 0.
  - Otherwise P = `ui_in` × 1024.
  - Changes to `ui_in` outside reset are ignored.
- Prescaler `cnt` (24 bit):
  - On each edge with `ena` high, `cnt` increments.
  - When `cnt` == P−1, it wraps to 0 and a tick occurs in that same edge.
- On a tick:
  - `digit` increments. Decimal mode wraps 9→0; see Configuration for hex mode.
  - `dp` (`uo_out[7]`) toggles.
- Segment decode is combinational from `digit`, with a-g in bits 0-6:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex).
  - Any undefined code displays 00 (blank).
- `ena` low freezes `cnt`, `digit` and `dp`. Outputs remain driven.
- Reset has priority over `ena` and over a tick in the same cycle.

## Timing
- Reset values:
  - `cnt`=0, `digit`=0, `dp`=0.
  - `uo_out`=8'h3F, `uio_out`=8'h00, `uio_oe`=8'h0F.
- Reset mid-count: at the next edge, `cnt`, `digit` and `dp` are cleared and P is reloaded. No partial tick survives.
- After reset is released with `ena` high, the first tick happens on the P-th rising edge. `digit`=1 is visible right after that edge.
- Subsequent ticks occur every P enabled edges.
- Outputs change only on the edge that updates `digit`/`dp`. There is zero additional latency beyond the register.
- With `ena` deasserted for k cycles, every later tick is delayed by exactly k cycles.

## Configuration
- `HEX_DISPLAY_EN` defined:
  - `digit` counts 0..15 and wraps 15→0.
  - Extra decode: A=77, b=7C, C=39, d=5E, E=79, F=71.
  - `uio_out[3:0]` carries the full hex value.
- `HEX_DISPLAY_EN` undefined:
  - Decimal counting 0..9 with 9→0 wrap.
  - Codes 10-15 are unreachable and decode to 00.

## Test plan
- Reset with `ui_in`=0, `ena`=1 held for 2 cycles → `uo_out`=3F, `uio_out`=00, `uio_oe`=0F.
- Reset with `ui_in`=1, then release:
  - At edge 1023 → still 3F.
  - At edge 1024 → `uo_out`=86 (digit 1, dp=1), `uio_out`=01.
- `ui_in`=1, run 10×1024 edges → digit wraps to 0, `uo_out`=3F (dp=0). Confirm all ten decode values en route.
- `ui_in`=2 (P=2048), drop `ena` for 500 cycles mid-period → tick arrives at edge 2548. Changing `ui_in` after reset leaves the period unchanged.
- Assert reset for one cycle while at digit 5, `cnt`=700 → next edge gives `uo_out`=3F, and the count restarts from 0.
- With `HEX_DISPLAY_EN`, `ui_in`=1 → after 10 ticks `uo_out[6:0]`=77; after 16 ticks back to 3F.
